// File: rtl/bitstream_output_buffer.sv
// Encoder output stage: packs 0-4 bytes per cycle into an in-order byte FIFO and drains
// one byte per cycle over valid/ready, flagging the frame's last byte and sticky errors.
//
// state    | meaning
// ST_RUN   | accepting writes; a write carrying the last byte moves to ST_FLUSH
// ST_FLUSH | writes refused; draining until the final byte is read
// ST_DONE  | frame fully drained; only reset leaves this state
module bitstream_output_buffer #(
  parameter int S5_BITSTREAM_WIDTH = 8,
  parameter int S5_ADDR_WIDTH      = 4,
  parameter int S5_CNT_WIDTH       = 32
) (
  input  logic                          s5_clk,
  input  logic                          s5_reset_n,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_last_bit,
  input  logic [2:0]                    in_flag_bitstream,
  input  logic                          in_flag_last,
  input  logic                          in_carry_error,
  output logic [S5_BITSTREAM_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_done,
  output logic                          out_almost_full,
  output logic                          out_error,
  output logic [S5_CNT_WIDTH-1:0]       out_byte_count
);

  localparam int DEPTH = 2 ** S5_ADDR_WIDTH;
  localparam int AW    = S5_ADDR_WIDTH;
  localparam int CW    = S5_ADDR_WIDTH + 1;
  localparam int BW    = S5_BITSTREAM_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    err_ovf_q, err_ovf_d;
  logic                    err_prot_q, err_prot_d;
  logic                    err_carry_q, err_carry_d;
  logic [S5_CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [BW-1:0]           mem_q [DEPTH];
  logic [BW-1:0]           mem_d [DEPTH];

  logic [3:0]    nwr;
  logic [3:0]    wr_n;
  logic [CW-1:0] free;
  logic          flag_illegal;
  logic          do_wr;
  logic          rd;
  logic [BW-1:0] wr_slot [4];

  always_comb begin
    nwr          = {1'b0, in_flag_bitstream} + {3'b000, in_flag_last};
    free         = DEPTH_C - count_q;
    flag_illegal = in_flag_bitstream > 3'd3;

    out_valid       = (count_q != '0) && (state_q != ST_DONE);
    out_last        = (state_q == ST_FLUSH) && (count_q == CW'(1));
    out_done        = (state_q == ST_DONE);
    out_almost_full = free < CW'(4);
    out_error       = err_ovf_q | err_prot_q | err_carry_q;
    out_byte_count  = byte_cnt_q;
    out_data        = out_valid ? mem_q[rd_ptr_q] : '0;
    rd              = out_valid & out_ready;

    // The last byte lands immediately after however many counted bytes precede it.
    wr_slot[0] = (in_flag_bitstream >= 3'd1) ? in_bit_1 : in_last_bit;
    wr_slot[1] = (in_flag_bitstream >= 3'd2) ? in_bit_2 : in_last_bit;
    wr_slot[2] = (in_flag_bitstream >= 3'd3) ? in_bit_3 : in_last_bit;
    wr_slot[3] = in_last_bit;

    state_d     = state_q;
    do_wr       = 1'b0;
    err_ovf_d   = err_ovf_q;
    err_prot_d  = err_prot_q;
    err_carry_d = err_carry_q | in_carry_error;

    case (state_q)
      ST_RUN: begin
        if (flag_illegal) begin
          err_prot_d = 1'b1;
        end else if (CW'(nwr) > free) begin
          // No credit for a same-cycle read: the whole write is refused.
          err_ovf_d = 1'b1;
        end else begin
          do_wr = 1'b1;
          if (in_flag_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flag_illegal || (nwr != 4'd0)) err_prot_d = 1'b1;
        if (rd && (count_q == CW'(1))) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (flag_illegal || (nwr != 4'd0)) err_prot_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    wr_n = do_wr ? nwr : 4'd0;

    mem_d = mem_q;
    for (int i = 0; i < 4; i++) begin
      if (4'(i) < wr_n) mem_d[wr_ptr_q + AW'(i)] = wr_slot[i];
    end

    wr_ptr_d   = wr_ptr_q + AW'(wr_n);
    rd_ptr_d   = rd_ptr_q + AW'(rd);
    count_d    = count_q + CW'(wr_n) - CW'(rd);
    byte_cnt_d = byte_cnt_q + S5_CNT_WIDTH'(rd);
  end

  always_ff @(posedge s5_clk or negedge s5_reset_n) begin
    if (!s5_reset_n) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_prot_q  <= 1'b0;
      err_carry_q <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_ovf_q   <= err_ovf_d;
      err_prot_q  <= err_prot_d;
      err_carry_q <= err_carry_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q and out_data is gated by out_valid.
  always_ff @(posedge s5_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_bitstream_output_buffer.sv
// Randomized and directed bench for bitstream_output_buffer against a queue-based frame model.
module tb_bitstream_output_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_bit_1, in_bit_2, in_bit_3, in_last_bit;
  logic [2:0]  in_flag_bitstream;
  logic        in_flag_last, in_carry_error;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last, out_done, out_almost_full, out_error;
  logic [31:0] out_byte_count;

  always #5 clk = ~clk;

  bitstream_output_buffer dut (
    .s5_clk            (clk),
    .s5_reset_n        (rst_n),
    .in_bit_1          (in_bit_1),
    .in_bit_2          (in_bit_2),
    .in_bit_3          (in_bit_3),
    .in_last_bit       (in_last_bit),
    .in_flag_bitstream (in_flag_bitstream),
    .in_flag_last      (in_flag_last),
    .in_carry_error    (in_carry_error),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .out_done          (out_done),
    .out_almost_full   (out_almost_full),
    .out_error         (out_error),
    .out_byte_count    (out_byte_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference: pending bytes as a queue, frame phase 0=open 1=closing 2=finished.
  byte unsigned m_q[$];
  int           m_phase;
  bit           m_ovf, m_prot, m_carry;
  int unsigned  m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_ovf   = 0;
    m_prot  = 0;
    m_carry = 0;
    m_cnt   = 0;
  endtask

  function automatic bit exp_valid();
    return (m_q.size() != 0) && (m_phase != 2);
  endfunction

  task automatic check_outputs();
    bit v;
    v = exp_valid();
    chk("valid", 32'(out_valid), 32'(v));
    chk("data", 32'(out_data), v ? 32'(m_q[0]) : 32'd0);
    chk("last", 32'(out_last), 32'((m_phase == 1) && (m_q.size() == 1)));
    chk("done", 32'(out_done), 32'(m_phase == 2));
    chk("almost_full", 32'(out_almost_full), 32'((16 - m_q.size()) < 4));
    chk("error", 32'(out_error), 32'(m_ovf | m_prot | m_carry));
    chk("byte_count", out_byte_count, m_cnt);
  endtask

  // Called at a negedge: checks current outputs, applies inputs, advances model over one edge.
  task automatic cycle(input int flag, input bit last, input byte unsigned b1, input byte unsigned b2,
                       input byte unsigned b3, input byte unsigned lb, input bit carry, input bit ready);
    bit rd;
    int nwr;
    bit ill;
    bit accept;
    byte unsigned bytes[$];
    check_outputs();
    in_flag_bitstream = flag[2:0];
    in_flag_last      = last;
    in_bit_1          = b1;
    in_bit_2          = b2;
    in_bit_3          = b3;
    in_last_bit       = lb;
    in_carry_error    = carry;
    out_ready         = ready;

    rd     = exp_valid() && ready;
    nwr    = flag + int'(last);
    ill    = flag > 3;
    accept = 0;
    if (flag >= 1) bytes.push_back(b1);
    if (flag >= 2) bytes.push_back(b2);
    if (flag >= 3) bytes.push_back(b3);
    if (last) bytes.push_back(lb);
    case (m_phase)
      0: begin
        if (ill) m_prot = 1;
        else if (nwr > 16 - m_q.size()) m_ovf = 1;
        else accept = 1;
      end
      1: begin
        if (ill || nwr != 0) m_prot = 1;
      end
      default: begin
        if (ill || nwr != 0) m_prot = 1;
      end
    endcase
    if (carry) m_carry = 1;

    @(posedge clk);
    if (m_phase == 1 && rd && m_q.size() == 1) m_phase = 2;
    if (rd) begin
      void'(m_q.pop_front());
      m_cnt++;
    end
    if (accept) begin
      foreach (bytes[i]) m_q.push_back(bytes[i]);
      if (last) m_phase = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, ready);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n             = 1'b0;
    in_flag_bitstream = 3'd0;
    in_flag_last      = 1'b0;
    in_carry_error    = 1'b0;
    out_ready         = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_bit_1 = 0; in_bit_2 = 0; in_bit_3 = 0; in_last_bit = 0;
    in_flag_bitstream = 0; in_flag_last = 0; in_carry_error = 0; out_ready = 0;
    model_reset();

    // Three bytes in one cycle, drained in order.
    do_reset();
    cycle(3, 0, 8'hA1, 8'hB2, 8'hC3, 8'h00, 0, 1);
    idle(4, 1);
    chk("t1_count", out_byte_count, 32'd3);

    // Frame close: two counted bytes plus the last byte, then done.
    cycle(2, 1, 8'h11, 8'h22, 8'h00, 8'h33, 0, 1);
    idle(5, 1);
    chk("t2_done", 32'(out_done), 32'd1);

    // Fill to full, then an overflowing write is refused.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(3, 0, 8'(i), 8'(i + 16), 8'(i + 32), 0, 0, 0);
    cycle(1, 0, 8'hEE, 0, 0, 0, 0, 0);
    chk("t3_af", 32'(out_almost_full), 32'd1);
    cycle(3, 0, 8'h99, 8'h98, 8'h97, 0, 0, 0);
    chk("t3_err", 32'(out_error), 32'd1);
    idle(18, 1);

    // Count 14, read and write of two together.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(3, 0, 8'(i + 1), 8'(i + 2), 8'(i + 3), 0, 0, 0);
    cycle(2, 0, 8'h55, 8'h66, 0, 0, 0, 0);
    cycle(2, 0, 8'h77, 8'h88, 0, 0, 0, 1);
    idle(17, 1);

    // Illegal flag, then a lone carry error.
    do_reset();
    cycle(5, 0, 8'h12, 8'h34, 8'h56, 0, 0, 1);
    idle(2, 1);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    idle(2, 1);

    // Asynchronous reset while draining seven bytes.
    do_reset();
    cycle(3, 0, 8'h01, 8'h02, 8'h03, 0, 1, 0);
    cycle(3, 0, 8'h04, 8'h05, 8'h06, 0, 0, 0);
    cycle(1, 0, 8'h07, 0, 0, 0, 0, 0);
    cycle(1, 0, 8'h08, 0, 0, 0, 0, 1);
    check_outputs();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_error", 32'(out_error), 32'd0);
    chk("t6_count", out_byte_count, 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1);

    // Random frames.
    for (int f = 0; f < 30; f++) begin
      int ncyc;
      int ready_bias;
      do_reset();
      ncyc       = $urandom_range(10, 60);
      ready_bias = $urandom_range(0, 3);
      for (int c = 0; c < ncyc; c++) begin
        int flag;
        flag = ($urandom_range(0, 24) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
        cycle(flag, $urandom_range(0, 29) == 0, 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(0, 99) == 0, $urandom_range(0, 3) < ready_bias + 1);
      end
      cycle(1, 1, 8'($urandom), 0, 0, 8'($urandom), 0, 1);
      idle(20, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
